// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the square and square-root blocks.
// Holds field widths, canonical special encodings and operand classification.
package fp_pkg;

    localparam int FP_BIAS = 127;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    // Denormals are flushed, so a zero exponent field always classifies as ZERO.
    function automatic fp_class_e fp_classify(input logic [EXP_W-1:0] exp_f,
                                              input logic [FRAC_W-1:0] frac_f);
        fp_class_e cls;
        if (exp_f == '0) begin
            cls = ZERO;
        end else if (exp_f == '1) begin
            cls = (frac_f != '0) ? NAN : INF;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_mant_mul_seq.sv
// Sequential shift-add significand multiplier: one partial product per cycle.
// product/valid hold their value until the next load.
module fp_mant_mul_seq #(
    parameter int MANT_W = 24,
    parameter int STEPS  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [MANT_W-1:0]     a,
    input  logic [MANT_W-1:0]     b,
    output logic [2*MANT_W-1:0]   product,
    output logic                  valid
);

    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    logic [2*MANT_W-1:0] mcand;
    logic [MANT_W-1:0]   mplier;
    logic [CNT_W-1:0]    count;
    logic                running;

    always_ff @(posedge clk) begin
        if (rst) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
            valid   <= 1'b0;
        end else if (load) begin
            product <= '0;
            mcand   <= {{MANT_W{1'b0}}, a};
            mplier  <= b;
            count   <= '0;
            running <= 1'b1;
            valid   <= 1'b0;
        end else if (running) begin
            // mcand is pre-shifted, so step k adds a<<k when bit k of b is set
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (count == LAST) begin
                running <= 1'b0;
                valid   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_square.sv
// Iterative single-precision squarer y = x*x with a fixed start-to-done latency.
// Special operands run the full multiply so every result takes the same time.
module fp_square
    import fp_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int MANT_W    = 24,
    parameter int LATENCY   = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] data_i,
    output logic [DATAWIDTH-1:0] data_o,
    output logic                 done,
    output logic                 busy
);

    localparam int PW = 2 * MANT_W;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_e;

    state_e              state;
    state_e              next_state;
    logic                mul_load;
    logic                mul_valid;
    logic [PW-1:0]       product;
    logic [MANT_W-1:0]   sig_i;
    logic [EXP_W-1:0]    exp_q;
    fp_class_e           cls_q;
    logic [DATAWIDTH-1:0] result;
    logic                sign_unused;

    // Squaring discards the operand sign; it is never consulted.
    assign sign_unused = data_i[DATAWIDTH-1];

    assign sig_i = {(data_i[FRAC_W +: EXP_W] != '0), data_i[FRAC_W-1:0]};

    // Normalise the 48-bit product, round to nearest-even, then range-check the exponent.
    function automatic logic [31:0] norm_round(input logic [PW-1:0] p,
                                               input logic [EXP_W-1:0] e_b);
        logic signed [9:0]  e;
        logic [MANT_W-2:0]  mant;
        logic               guard;
        logic               sticky;
        logic [MANT_W-1:0]  m_r;
        logic [31:0]        res;
        e = $signed({1'b0, e_b, 1'b0}) - $signed(10'(FP_BIAS));
        if (p[PW-1]) begin
            mant   = p[PW-2:MANT_W];
            guard  = p[MANT_W-1];
            sticky = |p[MANT_W-2:0];
            e      = e + 10'sd1;
        end else begin
            mant   = p[PW-3:MANT_W-1];
            guard  = p[MANT_W-2];
            sticky = |p[MANT_W-3:0];
        end
        m_r = {1'b0, mant} + {{(MANT_W-1){1'b0}}, guard & (sticky | mant[0])};
        // A carry out leaves the fraction all zeros; only the exponent moves.
        if (m_r[MANT_W-1]) begin
            e = e + 10'sd1;
        end
        if (e >= 10'sd255) begin
            res = POS_INF;
        end else if (e <= 10'sd0) begin
            res = 32'h0;
        end else begin
            res = {1'b0, e[7:0], m_r[MANT_W-2:0]};
        end
        return res;
    endfunction

    fp_mant_mul_seq #(
        .MANT_W (MANT_W),
        .STEPS  (LATENCY - 2)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .a       (sig_i),
        .b       (sig_i),
        .product (product),
        .valid   (mul_valid)
    );

    always_comb begin
        next_state = state;
        mul_load   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = MUL;
                    mul_load   = 1'b1;
                end
            end
            MUL: begin
                if (mul_valid) begin
                    next_state = NORM;
                end
            end
            NORM:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        result = '0;
        case (cls_q)
            ZERO:    result = '0;
            INF:     result = POS_INF;
            NAN:     result = QNAN;
            default: result = norm_round(product, exp_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            exp_q  <= '0;
            cls_q  <= ZERO;
            data_o <= '0;
        end else begin
            state <= next_state;
            if (mul_load) begin
                exp_q <= data_i[FRAC_W +: EXP_W];
                cls_q <= fp_classify(data_i[FRAC_W +: EXP_W], data_i[FRAC_W-1:0]);
            end
            if (state == NORM) begin
                data_o <= result;
            end
        end
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fp_square.sv
// Self-checking bench for fp_square: cycle-level timing model plus arithmetic reference.
module tb_fp_square;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference state: cycles left in the current operation and expected outputs
    int          rem    = 0;
    logic [31:0] data_m = 32'h0;
    logic [31:0] exp_val = 32'h0;
    bit          armed  = 1'b0;

    fp_square dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data_i (data_i),
        .data_o (data_o),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Exact integer square of the significand, then round-to-nearest-even by remainder.
    function automatic logic [31:0] ref_square(input logic [31:0] x);
        longint unsigned s, p, q, r, half;
        int e, sh;
        logic [7:0] ef;
        ef = x[30:23];
        if (ef == 8'hFF) return (x[22:0] != 0) ? 32'h7FC00000 : 32'h7F800000;
        if (ef == 8'h00) return 32'h0;
        s = (64'd1 << 23) | 64'(x[22:0]);
        p = s * s;
        e = 2 * int'(ef) - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = p >> sh;
        r    = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (r > half || (r == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return 32'h7F800000;
        if (e <= 0) return 32'h0;
        return {1'b0, e[7:0], q[22:0]};
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            rem    = 0;
            data_m = 32'h0;
            armed  = 1'b1;
        end else if (rem == 0) begin
            if (start) begin
                rem     = 27;
                exp_val = ref_square(data_i);
            end
        end else begin
            rem = rem - 1;
            if (rem == 1) data_m = exp_val;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy", 32'(busy), 32'(rem != 0));
            check("done", 32'(done), 32'(rem == 1));
            check("data_o", data_o, data_m);
        end
    end

    task automatic wait_done(input int n0, input logic [31:0] lit, input bit has_lit);
        int n;
        n = n0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 26);
        if (has_lit) check("literal", data_o, lit);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] lit, input bit has_lit);
        @(negedge clk);
        start  = 1'b1;
        data_i = x;
        @(negedge clk);
        start  = 1'b0;
        data_i = $urandom;
        wait_done(0, lit, has_lit);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] x;
        int sel;
        x   = $urandom;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       x[30:23] = 8'h00;
            1:       x[30:23] = 8'hFF;
            2, 3:    x[30:23] = 8'($urandom_range(60, 66));
            4, 5:    x[30:23] = 8'($urandom_range(187, 193));
            default: ;
        endcase
        return x;
    endfunction

    logic [31:0] dir_in  [0:9];
    logic [31:0] dir_out [0:9];

    initial begin
        int n_done, t1, t2, n;
        dir_in  = '{32'h40000000, 32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h60AD78EC,
                    32'h1E3CE508, 32'h00000001, 32'h7FC00001, 32'hFF800000, 32'h80000000};
        dir_out = '{32'h40800000, 32'h40100000, 32'h41100000, 32'h3F800002, 32'h7F800000,
                    32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
        rst    = 1'b1;
        start  = 1'b0;
        data_i = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_data_o", data_o, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_op(dir_in[i], dir_out[i], 1'b1);

        // start pulse while multiplying must be ignored
        @(negedge clk);
        start  = 1'b1;
        data_i = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start  = 1'b1;
        data_i = 32'h40400000;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, 32'h40800000, 1'b1);

        // reset in the middle of an operation aborts it
        @(negedge clk);
        start  = 1'b1;
        data_i = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_data_o", data_o, 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_op(32'h40000000, 32'h40800000, 1'b1);

        // start held high gives back-to-back operations
        @(negedge clk);
        start  = 1'b1;
        data_i = 32'h3FC00000;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        check("b2b_first", data_o, 32'h40100000);
        @(negedge clk);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        t2 = cyc;
        start = 1'b0;
        check("b2b_gap", t2 - t1, 28);
        check("b2b_second", data_o, 32'h40100000);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 200; i++) run_op(rand_operand(), 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_square.md
Name: fp_square

Overview:
- Iterative IEEE-754 single-precision squaring unit (y = x*x), the inverse-direction companion of the FP square-root block.
- Uses the same start/data_i/data_o handshake style, so benches can chain sqrt -> square and compare the result to the original input.
- Mantissa product is built with a 24-cycle shift-add multiplier.
- Latency is fixed for every input class, including special values.

Parameters:
- DATAWIDTH, 32, operand/result width; only 32 is supported.
- MANT_W, 24, significand width including the hidden bit.
- LATENCY, 26, cycles from the start-capture edge to the done pulse; informational, not configurable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; level-sampled only in IDLE.
- data_i  input  32  IEEE-754 single operand; sampled on the edge where start is accepted.
- data_o  output  32  result; held stable from the done pulse until the next accepted start.
- done  output  1  one-cycle pulse when data_o becomes valid.
- busy  output  1  high from the cycle after start is accepted until done deasserts.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, data_o=32'h0, done=0, busy=0, all datapath regs cleared.
- rst has priority over every other event, including an in-flight operation and a done pulse in the same cycle.
- FSM states: IDLE, MUL, NORM, DONE.
- IDLE -> MUL: on an edge with start=1.
  - Latch data_i.
  - Classify the operand.
  - Multiplier counter = 0.
  - acc = 0; multiplicand = multiplier = {hidden,frac}.
- MUL: one partial-product step per cycle (if multiplier LSB, acc += multiplicand<<k); exits to NORM after exactly 24 cycles (counter 0..23).
- NORM (1 cycle):
  - Normalise the 48-bit product: if P[47]=1, take mantissa P[46:24] and exp+1; otherwise take P[45:23].
  - Round to nearest, ties to even, using guard bit and sticky OR of the remaining bits.
  - If rounding carries out, renormalise and exp+1.
- DONE: register data_o, done=1 for exactly one cycle, then -> IDLE.
- start in DONE or MUL/NORM is ignored.
- start still high on return to IDLE begins a new operation.
- Timing: start accepted at edge T -> done high in the cycle after edge T+26 (NORM at edge T+25, DONE at T+26).
- Exponent arithmetic:
  - Signed 10-bit unbiased computation: e = 2*E - 127.
  - e >= 255 after normalisation/rounding -> +Inf (32'h7F800000).
  - e <= 0 -> +0 (no denormal outputs; flush to zero).
- Sign: result sign is always 0 for non-NaN inputs (-3.0 squared is +9.0).
- Special inputs: special values still traverse MUL/NORM so latency stays fixed; the class flag overrides the result in NORM.
  - E=0, zero or denormal (flushed) -> +0.
  - Inf (either sign) -> +Inf.
  - NaN (any payload) -> canonical 32'h7FC00000.
- Reset mid-operation aborts the operation with no done pulse; data_o is forced to 0.
- busy = (state != IDLE).

Decomposition:
- Shared package fp_pkg:
  - Constants FP_BIAS=127, EXP_W=8, FRAC_W=23.
  - Constants QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - Operand-class enum {ZERO, NORMAL, INF, NAN}.
  - fp_classify function.
  - Fields reusable by the sqrt block.
- One sub-module, fp_mant_mul_seq: 24x24 sequential shift-add multiplier.
  - Ports: load, 24-bit a/b in, 48-bit product out, valid after 24 cycles.
  - Controlled by the fp_square FSM.

Test Plan:
- Data_i=32'h40000000 (2.0), start for 1 cycle -> done exactly 26 cycles after the accept edge, data_o=32'h40800000 (4.0); busy high throughout.
- 32'h3FC00000 (1.5) -> 32'h40100000 (2.25); 32'hC0400000 (-3.0) -> 32'h41100000 (+9.0).
- Rounding: 32'h3F800001 -> 32'h3F800002 (1+2^-22; the 2^-46 term drops via RNE).
- Range: 32'h60AD78EC (~1e20) -> 32'h7F800000; 32'h1E3CE508 (~1e-20) -> 32'h00000000; 32'h00000001 (denormal) -> 32'h00000000.
- Specials: 32'h7FC00001 -> 32'h7FC00000; 32'hFF800000 (-Inf) -> 32'h7F800000; 32'h80000000 (-0) -> 32'h00000000. Each case has latency 26.
- Control:
  - start pulsed during MUL is ignored.
  - rst asserted at cycle 10 of an operation -> no done pulse, data_o=0, state returns to IDLE.
  - A following start with 32'h40000000 completes normally.
  - start held high continuously -> back-to-back results, done pulses 28 cycles apart.
